fifo_level: RTL



---
 rtl/fifo_level_if.sv | 22 ++
 rtl/fifo_level.sv | 111 +++++++++++
 2 files changed

// File: rtl/fifo_level_if.sv
// Valid/ready bundle for the level-tracking FIFO.
// Enqueue channel (enq_*) and dequeue channel (deq_*); master drives, slave is the FIFO.
interface fifo_level_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] enq_data;
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] deq_data;
  logic              deq_valid;
  logic              deq_ready;

  modport master (
    output enq_data, enq_valid, deq_ready,
    input  enq_ready, deq_data, deq_valid
  );

  modport slave (
    input  enq_data, enq_valid, deq_ready,
    output enq_ready, deq_data, deq_valid
  );
endinterface

// File: rtl/fifo_level.sv
// Single-clock FIFO with occupancy count, almost flags and sticky high-water mark.
// Ports: clk, rst, flush, hwm_clr, bus (enq/deq handshakes), count, full, empty, almost_*, hwm.
module fifo_level #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int AF_LEVEL    = DEPTH - 1,
  parameter int AE_LEVEL    = 1,
  parameter bit ENQ_ON_FULL = 1'b0,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          hwm_clr,
  fifo_level_if.slave   bus,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] hwm
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_level: DEPTH must be >= 2");
  end
  if (DATA_W < 1) begin : g_bad_width
    $fatal(1, "fifo_level: DATA_W must be >= 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_level: AF_LEVEL out of range");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_level: AE_LEVEL out of range");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic [CW-1:0]     hwm_nxt;
  logic              enq_fire;
  logic              deq_fire;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = count == CW'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= CW'(AF_LEVEL);
  assign almost_empty = count <= CW'(AE_LEVEL);

  // With ENQ_ON_FULL the slot being vacated this cycle can take the write.
  assign bus.enq_ready = !full || (ENQ_ON_FULL && bus.deq_ready);
  assign bus.deq_valid = !empty;
  assign bus.deq_data  = mem[rd_ptr];

  assign enq_fire = bus.enq_valid && bus.enq_ready;
  assign deq_fire = bus.deq_valid && bus.deq_ready;

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (enq_fire && !deq_fire) begin
      count_nxt = count + 1'b1;
    end else if (deq_fire && !enq_fire) begin
      count_nxt = count - 1'b1;
    end
  end

  always_comb begin
    hwm_nxt = hwm;
    if (hwm_clr) begin
      hwm_nxt = count_nxt;
    end else if (count_nxt > hwm) begin
      hwm_nxt = count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hwm    <= '0;
    end else begin
      count <= count_nxt;
      hwm   <= hwm_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (enq_fire) wr_ptr <= inc(wr_ptr);
        if (deq_fire) rd_ptr <= inc(rd_ptr);
      end
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush && enq_fire) begin
      mem[wr_ptr] <= bus.enq_data;
    end
  end

endmodule
